// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned NxN multiplier with runtime-selectable approximate mode.
// Approximate mode truncates low columns and OR-compresses a band within each partial-product row pair.
module approx_mult_pipe #(
  parameter int unsigned N   = 8,
  parameter int unsigned L   = 6,
  parameter int unsigned ORW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   z,
  output logic             z_approx
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned NP = N / 2;

  function automatic logic [W2-1:0] col_mask(input int unsigned lo, input int unsigned hi);
    logic [W2-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < W2; c++) begin
      m[c] = (c >= lo) && (c < hi);
    end
    return m;
  endfunction

  localparam logic [W2-1:0] BAND_MASK = col_mask(L, L + ORW);
  localparam logic [W2-1:0] HI_MASK   = col_mask(L + ORW, W2);

  logic              advance_c;
  logic              v1_q, v2_q, ov_q;
  logic [N-1:0]      x1_q, y1_q;
  logic              a1_q, a2_q, za_q;
  logic [W2-1:0]     pair_d [NP];
  logic [W2-1:0]     pair_q [NP];
  logic [W2-1:0]     psum_c [NP+1];
  logic [W2-1:0]     z_d, z_q;

  assign advance_c = !ov_q || out_ready;
  assign in_ready  = advance_c;
  assign out_valid = ov_q;
  assign z         = z_q;
  assign z_approx  = za_q;

  // Stage 2: each row pair collapses into one vector; the top pair is always exact.
  for (genvar k = 0; k < NP; k++) begin : g_pair
    logic [W2-1:0] r0_c, r1_c;
    assign r0_c = W2'(y1_q & {N{x1_q[2*k]}}) << (2 * k);
    assign r1_c = W2'(y1_q & {N{x1_q[2*k+1]}}) << (2 * k + 1);
    if (k < NP - 1) begin : g_apx
      assign pair_d[k] = a1_q ? (((r0_c | r1_c) & BAND_MASK) + (r0_c & HI_MASK) + (r1_c & HI_MASK))
                              : (r0_c + r1_c);
    end else begin : g_top
      assign pair_d[k] = r0_c + r1_c;
    end
  end

  // Stage 3: final carry-propagate sum of the pair vectors.
  assign psum_c[0] = '0;
  for (genvar k = 0; k < NP; k++) begin : g_sum
    assign psum_c[k+1] = psum_c[k] + pair_q[k];
  end
  assign z_d = psum_c[NP];

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
      z_q  <= '0;
      za_q <= 1'b0;
    end else if (advance_c) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      ov_q <= v2_q;
      if (v2_q) begin
        z_q  <= z_d;
        za_q <= a2_q;
      end
    end
  end

  // Datapath registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance_c) begin
      x1_q   <= x;
      y1_q   <= y;
      a1_q   <= approx_en;
      a2_q   <= a1_q;
      pair_q <= pair_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Randomized bench for approx_mult_pipe: cycle-level transaction model plus column-rule golden product.
module tb_approx_mult_pipe;

  localparam int TN = 8;
  localparam int TL = 6;
  localparam int TORW = 2;

  typedef struct packed {
    logic        v;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ae;
    logic [15:0] ez;
    logic [3:0]  x4;
    logic [3:0]  y4;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, approx_en, out_valid, out_ready, z_approx;
  logic [7:0]  x, y;
  logic [15:0] z;
  logic        in_ready4, out_valid4, z_approx4;
  logic [3:0]  x4, y4;
  logic [7:0]  z4;

  int   checks = 0;
  int   errors = 0;
  txn_t mp [3];
  logic armed = 1'b0;
  logic chk_zero = 1'b0;
  logic last_acc;

  always #5 clk = ~clk;

  approx_mult_pipe #(.N(8), .L(6), .ORW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .z_approx(z_approx)
  );

  approx_mult_pipe #(.N(4), .L(0), .ORW(0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .x(x4), .y(y4), .approx_en(approx_en), .out_valid(out_valid4),
    .out_ready(out_ready), .z(z4), .z_approx(z_approx4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int bitat(input logic [7:0] xx, input logic [7:0] yy, input int i, input int c);
    if (((int'(xx) >> i) & 1) == 1 && c >= i && c - i < TN) return (int'(yy) >> (c - i)) & 1;
    return 0;
  endfunction

  // Golden product from the per-column rules.
  function automatic logic [15:0] golden(input logic [7:0] xx, input logic [7:0] yy, input logic ae);
    logic [15:0] p;
    int acc, a, b;
    p = xx * yy;
    if (!ae) return p;
    acc = 0;
    for (int k = 0; k < (TN - 2) / 2; k++) begin
      for (int c = 0; c < 2 * TN; c++) begin
        a = bitat(xx, yy, 2 * k, c);
        b = bitat(xx, yy, 2 * k + 1, c);
        if (c < TL) acc += 0;
        else if (c < TL + TORW) acc += (a | b) << c;
        else acc += (a + b) << c;
      end
    end
    acc += (int'(yy) * int'(xx[7:6])) << (TN - 2);
    return 16'(acc);
  endfunction

  function automatic txn_t mk(input logic [7:0] xx, input logic [7:0] yy, input logic ae,
                              input logic [15:0] ez, input logic [3:0] a4, input logic [3:0] b4);
    txn_t t;
    t.v = 1'b1; t.x = xx; t.y = yy; t.ae = ae; t.ez = ez; t.x4 = a4; t.y4 = b4;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    logic [7:0] xx, yy;
    logic ae;
    xx = 8'($urandom); yy = 8'($urandom); ae = 1'($urandom);
    return mk(xx, yy, ae, golden(xx, yy, ae), 4'($urandom), 4'($urandom));
  endfunction

  // One clock: drive at negedge, check outputs, then advance the transaction model.
  task automatic cycle(input logic r, input logic iv, input txn_t t, input logic ordy);
    logic [15:0] prod;
    logic [7:0]  p4;
    logic        adv;
    @(negedge clk);
    rst = r; in_valid = iv; x = t.x; y = t.y; approx_en = t.ae;
    x4 = t.x4; y4 = t.y4; out_ready = ordy;
    #1;
    if (armed) begin
      if (chk_zero) begin
        chk("rst_z", 32'(z), 0);
        chk("rst_zapx", 32'(z_approx), 0);
        chk_zero = 1'b0;
      end
      chk("out_valid", 32'(out_valid), 32'(mp[2].v));
      chk("out_valid4", 32'(out_valid4), 32'(mp[2].v));
      if (mp[2].v) begin
        prod = mp[2].x * mp[2].y;
        p4 = mp[2].x4 * mp[2].y4;
        chk("z", 32'(z), 32'(mp[2].ez));
        chk("z_approx", 32'(z_approx), 32'(mp[2].ae));
        chk("z_le_xy", 32'(z <= prod), 1);
        chk("z4", 32'(z4), 32'(p4));
      end
      if (!r) chk("in_ready", 32'(in_ready), 32'(!mp[2].v || ordy));
    end
    adv = !mp[2].v || ordy;
    last_acc = !r && iv && adv;
    if (r) begin
      for (int i = 0; i < 3; i++) mp[i].v = 1'b0;
      chk_zero = 1'b1;
    end else if (adv) begin
      mp[2] = mp[1];
      mp[1] = mp[0];
      mp[0] = t;
      mp[0].v = iv;
    end
    armed = 1'b1;
  endtask

  txn_t idle;
  txn_t dir [6];
  txn_t pend;
  logic rdy_pat [4];

  initial begin
    idle = '0;
    for (int i = 0; i < 3; i++) mp[i] = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; approx_en = 1'b0;
    x = '0; y = '0; x4 = '0; y4 = '0;

    cycle(1'b1, 1'b0, idle, 1'b0);
    cycle(1'b1, 1'b0, idle, 1'b0);
    cycle(1'b0, 1'b0, idle, 1'b0);

    // Directed products with hand-derived expectations.
    dir[0] = mk(8'd255, 8'd255, 1'b0, 16'd65025, 4'd15, 4'd15);
    dir[1] = mk(8'd255, 8'd255, 1'b1, 16'd64128, 4'd0, 4'd9);
    dir[2] = mk(8'd3, 8'd5, 1'b1, 16'd0, 4'd3, 4'd5);
    dir[3] = mk(8'd64, 8'd200, 1'b1, 16'd12800, 4'd8, 4'd12);
    dir[4] = mk(8'd0, 8'd173, 1'b1, 16'd0, 4'd7, 4'd0);
    dir[5] = mk(8'd91, 8'd0, 1'b0, 16'd0, 4'd1, 4'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, dir[i], 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, idle, 1'b1);

    // Back-pressure with out_ready pattern 1,0,0,1.
    rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
    begin
      int sent, cyc;
      sent = 0; cyc = 0;
      pend = rnd_txn();
      while (sent < 6 && cyc < 200) begin
        cycle(1'b0, 1'b1, pend, rdy_pat[cyc % 4]);
        cyc++;
        if (last_acc) begin sent++; pend = rnd_txn(); end
      end
      chk("bp_sent", 32'(sent), 6);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, idle, rdy_pat[i % 4]);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, idle, 1'b1);
    end

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rnd_txn(), 1'b1);
    cycle(1'b1, 1'b0, idle, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, idle, 1'b1);

    // Full 4-bit sweep on the exact-configured instance, approximate mode.
    for (int i = 0; i < 256; i++) begin
      pend = rnd_txn();
      pend.ae = 1'b1;
      pend.ez = golden(pend.x, pend.y, 1'b1);
      pend.x4 = 4'(i);
      pend.y4 = 4'(i >> 4);
      cycle(1'b0, 1'b1, pend, 1'b1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, idle, 1'b1);

    // Random traffic with random valid and back-pressure.
    begin
      int sent, cyc;
      logic iv;
      sent = 0; cyc = 0;
      pend = rnd_txn();
      while (sent < 10000 && cyc < 40000) begin
        iv = ($urandom_range(0, 4) != 0);
        cycle(1'b0, iv, pend, $urandom_range(0, 3) != 0);
        cyc++;
        if (last_acc) begin sent++; pend = rnd_txn(); end
      end
      chk("rand_sent", 32'(sent), 10000);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, idle, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
